// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_resp
// Purpose  : CPU data-RAM responder with a posted store buffer, same-cycle
//            load forwarding, and a loader write port sharing the array.
// Revision : 1.0  initial release
// ============================================================================
module data_ram_resp #(
    parameter int ADDR_WIDTH = 10,
    parameter int SB_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ram_en_i,
    input  logic                        ram_write_en_i,
    input  logic [31:0]                 ram_addr_i,
    input  logic [31:0]                 ram_data_i,
    input  logic [3:0]                  ram_select_i,
    output logic [31:0]                 ram_data_o,
    input  logic                        ext_wr_i,
    input  logic [ADDR_WIDTH-1:0]       ext_addr_i,
    input  logic [31:0]                 ext_data_i,
    output logic                        ext_busy_o,
    output logic [$clog2(SB_DEPTH):0]   sb_count_o,
    output logic                        sb_empty_o
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q     [WORDS];
    logic [ADDR_WIDTH-1:0] sb_addr_q [SB_DEPTH];
    logic [31:0]           sb_data_q [SB_DEPTH];
    logic [3:0]            sb_sel_q  [SB_DEPTH];
    logic [SB_DEPTH-1:0]   sb_valid_q, sb_valid_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ADDR_WIDTH-1:0] w_cpu_word;
    logic                  w_push, w_pop, w_ext_we, w_full;
    logic [PTR_W-1:0]      w_fwd_idx;
    logic [31:0]           w_rd_data;
    logic                  w_unused;

    assign w_unused   = ^{ram_addr_i[31:ADDR_WIDTH+2], ram_addr_i[1:0]};
    assign w_cpu_word = ram_addr_i[ADDR_WIDTH+1:2];

    // The drain is forced when full, so a store arriving at full never overflows.
    assign w_full   = (count_q == CNT_W'(SB_DEPTH));
    assign w_push   = ram_en_i & ram_write_en_i & (ram_select_i != 4'b0000);
    assign w_pop    = (count_q != '0) & (w_full | ~ext_wr_i);
    assign w_ext_we = ext_wr_i & ~w_full;

    assign ext_busy_o = ext_wr_i & w_full;
    assign sb_count_o = count_q;
    assign sb_empty_o = (count_q == '0);

    always_comb begin
        head_d     = w_pop  ? head_q + PTR_W'(1) : head_q;
        tail_d     = w_push ? tail_q + PTR_W'(1) : tail_q;
        count_d    = count_q;
        sb_valid_d = sb_valid_q;
        if (w_pop)  sb_valid_d[head_q] = 1'b0;
        if (w_push) sb_valid_d[tail_q] = 1'b1;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sb_valid_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            sb_valid_q <= sb_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            sb_addr_q[tail_q] <= w_cpu_word;
            sb_data_q[tail_q] <= ram_data_i;
            sb_sel_q[tail_q]  <= ram_select_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            for (int b = 0; b < 4; b++) begin
                if (sb_sel_q[head_q][b])
                    mem_q[sb_addr_q[head_q]][8*b +: 8] <= sb_data_q[head_q][8*b +: 8];
            end
        end else if (w_ext_we) begin
            mem_q[ext_addr_i] <= ext_data_i;
        end
    end

    // Walk entries oldest to youngest so the youngest matching lane wins.
    always_comb begin
        w_rd_data = mem_q[w_cpu_word];
        w_fwd_idx = head_q;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_fwd_idx = head_q + PTR_W'(i);
            if (sb_valid_q[w_fwd_idx] && (sb_addr_q[w_fwd_idx] == w_cpu_word)) begin
                for (int b = 0; b < 4; b++) begin
                    if (sb_sel_q[w_fwd_idx][b])
                        w_rd_data[8*b +: 8] = sb_data_q[w_fwd_idx][8*b +: 8];
                end
            end
        end
        ram_data_o = (ram_en_i && !ram_write_en_i) ? w_rd_data : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_resp
// Purpose  : Directed + randomized self-checking bench for data_ram_resp.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_ram_resp;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_en_i = 1'b0, ram_write_en_i = 1'b0;
    logic [31:0] ram_addr_i = '0, ram_data_i = '0;
    logic [3:0]  ram_select_i = '0;
    logic [31:0] ram_data_o;
    logic        ext_wr_i = 1'b0;
    logic [AW-1:0] ext_addr_i = '0;
    logic [31:0] ext_data_i = '0;
    logic        ext_busy_o;
    logic [$clog2(DEPTH):0] sb_count_o;
    logic        sb_empty_o;

    always #5 clk = ~clk;

    data_ram_resp #(.ADDR_WIDTH(AW), .SB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ram_en_i(ram_en_i), .ram_write_en_i(ram_write_en_i),
        .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i),
        .ram_select_i(ram_select_i), .ram_data_o(ram_data_o),
        .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i), .ext_data_i(ext_data_i),
        .ext_busy_o(ext_busy_o), .sb_count_o(sb_count_o), .sb_empty_o(sb_empty_o)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    s;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [1<<AW];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Array word overlaid with every pending store in program order.
    function automatic logic [31:0] model_read(input logic [AW-1:0] idx);
        logic [31:0] w;
        w = mem_m[idx];
        foreach (q[i]) begin
            if (q[i].a == idx)
                for (int b = 0; b < 4; b++)
                    if (q[i].s[b]) w[8*b +: 8] = q[i].d[8*b +: 8];
        end
        return w;
    endfunction

    logic [AW-1:0] m_cw;
    logic [31:0]   m_exp;
    logic          m_full;
    ent_t          m_e;

    // Outputs checked mid-cycle; model then advances to the coming edge.
    always @(negedge clk) begin
        if (rst) q.delete();
        m_cw   = ram_addr_i[AW+1:2];
        m_full = (q.size() == DEPTH);
        m_exp  = (ram_en_i && !ram_write_en_i) ? model_read(m_cw) : 32'h0;
        chk("rdata", ram_data_o, m_exp);
        chk("count", 32'(sb_count_o), 32'(q.size()));
        chk("empty", 32'(sb_empty_o), 32'(q.size() == 0));
        chk("busy",  32'(ext_busy_o), 32'(ext_wr_i && m_full));
        if (!rst && q.size() != 0 && (m_full || !ext_wr_i)) begin
            m_e = q.pop_front();
            for (int b = 0; b < 4; b++)
                if (m_e.s[b]) mem_m[m_e.a][8*b +: 8] = m_e.d[8*b +: 8];
        end else if (ext_wr_i && !m_full) begin
            mem_m[ext_addr_i] = ext_data_i;
        end
        if (!rst && ram_en_i && ram_write_en_i && ram_select_i != 4'b0) begin
            m_e.a = m_cw; m_e.d = ram_data_i; m_e.s = ram_select_i;
            q.push_back(m_e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ram_en_i = 1'b0; ram_write_en_i = 1'b0; ram_select_i = '0; ext_wr_i = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ram_en_i = 1'b1; ram_write_en_i = 1'b1; ram_addr_i = a; ram_data_i = d; ram_select_i = s;
    endtask

    task automatic load(input logic [31:0] a);
        ram_en_i = 1'b1; ram_write_en_i = 1'b0; ram_addr_i = a; ram_select_i = '0;
    endtask

    task automatic loader(input logic en, input logic [AW-1:0] a, input logic [31:0] d);
        ext_wr_i = en; ext_addr_i = a; ext_data_i = d;
    endtask

    logic [31:0] r;

    initial begin
        repeat (3) tick();
        chk("reset_count", 32'(sb_count_o), 32'd0);
        chk("reset_empty", 32'(sb_empty_o), 32'd1);
        chk("reset_busy",  32'(ext_busy_o), 32'd0);
        rst = 1'b0;
        tick();

        // Preload words 0..15
        for (int w = 0; w < 16; w++) begin
            r = (w == 4) ? 32'h1122_3344 : (w == 8) ? 32'hA0A0_A0A0 :
                (w == 5) ? 32'h5A5A_5A5A : 32'h0101_0101 * w;
            loader(1'b1, AW'(w), r);
            tick();
        end
        loader(1'b0, '0, '0);

        load(32'h10); #1;
        chk("preload_rd", ram_data_o, 32'h1122_3344);
        chk("preload_empty", 32'(sb_empty_o), 32'd1);
        tick();

        // Partial store, drain stalled by loader
        store(32'h10, 32'hAABB_CCDD, 4'b0011);
        loader(1'b1, AW'(15), 32'hDEAD_BEEF);
        tick();
        load(32'h10); #1;
        chk("fwd_partial", ram_data_o, 32'h1122_CCDD);
        chk("fwd_count", 32'(sb_count_o), 32'd1);
        tick();
        idle(); #1;
        chk("stall_count", 32'(sb_count_o), 32'd1);
        tick();
        chk("drained_empty", 32'(sb_empty_o), 32'd1);
        load(32'h10); #1;
        chk("drained_rd", ram_data_o, 32'h1122_CCDD);
        tick();

        // Youngest-match per lane
        loader(1'b1, AW'(15), 32'hDEAD_BEEF);
        store(32'h20, 32'h0000_00FF, 4'b0001); tick();
        store(32'h20, 32'h0000_EE00, 4'b0010); tick();
        load(32'h20); #1;
        chk("lane_merge", ram_data_o, 32'hA0A0_EEFF);
        tick();

        // Fill to full; store at full with refused loader write
        store(32'h30, 32'h3333_3333, 4'b1111); tick();
        store(32'h34, 32'h4444_4444, 4'b1111); tick();
        store(32'h38, 32'h0BAD_F00D, 4'b1111);
        loader(1'b1, AW'(8), 32'h5555_5555); #1;
        chk("full_count", 32'(sb_count_o), 32'd4);
        chk("full_busy",  32'(ext_busy_o), 32'd1);
        tick();
        idle(); #1;
        chk("full_push_count", 32'(sb_count_o), 32'd4);
        chk("idle_busy", 32'(ext_busy_o), 32'd0);
        repeat (4) tick();
        chk("full_drained", 32'(sb_empty_o), 32'd1);
        load(32'h20); #1;
        chk("refused_loader", ram_data_o, 32'hA0A0_EEFF);
        tick();
        load(32'h38); #1;
        chk("fifth_store", ram_data_o, 32'h0BAD_F00D);
        tick();

        // Buffered store lands after same-cycle loader write
        store(32'h20, 32'h1234_5678, 4'b1111);
        loader(1'b1, AW'(8), 32'h5555_5555);
        tick();
        idle(); tick();
        load(32'h20); #1;
        chk("store_over_loader", ram_data_o, 32'h1234_5678);
        tick();

        // Async reset discards pending stores
        loader(1'b1, AW'(15), 32'hDEAD_BEEF);
        store(32'h14, 32'h0000_0011, 4'b0001); tick();
        store(32'h14, 32'h0000_2200, 4'b0010); tick();
        store(32'h14, 32'h9999_9999, 4'b1111); tick();
        idle(); #1;
        chk("pre_reset_count", 32'(sb_count_o), 32'd3);
        rst = 1'b1;
        load(32'h14); #1;
        chk("async_count", 32'(sb_count_o), 32'd0);
        chk("async_empty", 32'(sb_empty_o), 32'd1);
        chk("discarded_rd", ram_data_o, 32'h5A5A_5A5A);
        tick(); tick();
        rst = 1'b0;
        idle(); tick();

        // Randomized traffic on words 0..15 with junk upper/low address bits
        for (int n = 0; n < 3000; n++) begin
            r = $urandom();
            ram_en_i       = r[0];
            ram_write_en_i = r[1];
            ram_select_i   = $urandom_range(0, 15);
            ram_data_i     = $urandom();
            ram_addr_i     = {r[31:12], 6'b0, 4'($urandom_range(0, 15)), r[3:2]};
            ext_wr_i       = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ext_addr_i     = AW'($urandom_range(0, 15));
            ext_data_i     = $urandom();
            tick();
        end
        idle(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
